// File: rtl/div_pkg.sv
// Shared types and constants for the divider dispatch stage.
// Holds the opcode encodings, FSM state enum and the default request entry layout.
package div_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_TAG_W = 4;

  localparam logic DIV_OP_UNSIGNED = 1'b0;
  localparam logic DIV_OP_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } div_state_e;

  typedef struct packed {
    logic                 opcode;
    logic [DIV_XLEN-1:0]  dividend;
    logic [DIV_XLEN-1:0]  divisor;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

endpackage

// File: rtl/div_int_dispatch_if.sv
// Request, divider-issue and response signals of the dispatch stage.
// slave = dispatch stage view, master = surrounding environment view.
interface div_int_dispatch_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_opcode;
  logic [XLEN-1:0]  req_dividend;
  logic [XLEN-1:0]  req_divisor;
  logic [TAG_W-1:0] req_tag;

  logic             div_valid_in;
  logic             div_opcode;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_valid_out;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_quotient;
  logic [XLEN-1:0]  rsp_remainder;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_opcode, req_dividend, req_divisor, req_tag,
    output req_ready,
    output div_valid_in, div_opcode, div_dividend, div_divisor,
    input  div_valid_out, div_quotient, div_remainder,
    output rsp_valid, rsp_quotient, rsp_remainder, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opcode, req_dividend, req_divisor, req_tag,
    input  req_ready,
    input  div_valid_in, div_opcode, div_dividend, div_divisor,
    output div_valid_out, div_quotient, div_remainder,
    input  rsp_valid, rsp_quotient, rsp_remainder, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/div_req_fifo.sv
// In-order request FIFO, DEPTH entries (power of 2); head visible combinationally.
// Push is dropped when full and pop when empty; simultaneous push/pop both take effect.
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/div_int_dispatch.sv
// Queues divide requests and issues one at a time to div_int; returns tagged results.
// Optional DIV_DISPATCH_ZERO_BYPASS_EN answers divide-by-zero locally without using the divider.
module div_int_dispatch
  import div_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = DIV_TAG_W,
  parameter int XLEN  = DIV_XLEN
) (
  input logic              clock,
  input logic              reset,
  div_int_dispatch_if.slave bus
);
  typedef struct packed {
    logic             opcode;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     push_entry;
  entry_t     head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       issue;
  logic       bypass;
  logic       capture;
  logic       rsp_done;
  div_state_e state_q;
  div_state_e state_d;

  logic             div_valid_q;
  logic             div_opcode_q;
  logic [XLEN-1:0]  div_dividend_q;
  logic [XLEN-1:0]  div_divisor_q;
  logic [TAG_W-1:0] inflight_tag_q;
  logic             rsp_valid_q;
  logic [XLEN-1:0]  rsp_quotient_q;
  logic [XLEN-1:0]  rsp_remainder_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign push_entry    = {bus.req_opcode, bus.req_dividend, bus.req_divisor, bus.req_tag};
  assign bus.req_ready = !full;

  div_req_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.req_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    issue    = 1'b0;
    bypass   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
          if (head.divisor == '0) begin
            bypass  = 1'b1;
            state_d = S_HOLD;
          end else begin
            issue   = 1'b1;
            state_d = S_BUSY;
          end
`else
          issue   = 1'b1;
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (bus.div_valid_out) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands persist after the issue pulse so the divider may sample them late.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_valid_q     <= 1'b0;
      div_opcode_q    <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      inflight_tag_q  <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_tag_q       <= '0;
    end else begin
      div_valid_q <= issue;
      if (issue) begin
        div_opcode_q   <= head.opcode;
        div_dividend_q <= head.dividend;
        div_divisor_q  <= head.divisor;
        inflight_tag_q <= head.tag;
      end
      if (capture) begin
        rsp_valid_q     <= 1'b1;
        rsp_quotient_q  <= bus.div_quotient;
        rsp_remainder_q <= bus.div_remainder;
        rsp_tag_q       <= inflight_tag_q;
      end else if (bypass) begin
        rsp_valid_q     <= 1'b1;
        rsp_quotient_q  <= '1;
        rsp_remainder_q <= head.dividend;
        rsp_tag_q       <= head.tag;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.div_valid_in  = div_valid_q;
  assign bus.div_opcode    = div_opcode_q;
  assign bus.div_dividend  = div_dividend_q;
  assign bus.div_divisor   = div_divisor_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_quotient  = rsp_quotient_q;
  assign bus.rsp_remainder = rsp_remainder_q;
  assign bus.rsp_tag       = rsp_tag_q;
endmodule

// File: tb/tb_div_int_dispatch.sv
// Directed bench for div_int_dispatch with a behavioural divider and response scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_div_int_dispatch;
  import div_pkg::*;

  localparam int DIV_LAT = 3;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  tag;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  div_int_dispatch_if #(.XLEN(32), .TAG_W(4)) bus ();

  div_int_dispatch #(.DEPTH(4), .TAG_W(4), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   issue_cnt = 0;
  bit   stray_req = 1'b0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic void ref_div(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (op == DIV_OP_SIGNED) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Behavioural divider: fixed latency, aborts on reset, can emit one stray strobe.
  initial begin
    bit          busy = 1'b0;
    int          lat  = 0;
    logic [31:0] pq, pr;
    bus.div_valid_out = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    forever begin
      @(negedge clock);
      bus.div_valid_out = 1'b0;
      if (!reset) begin
        busy = 1'b0;
        continue;
      end
      if (busy) begin
        if (lat == 0) begin
          bus.div_valid_out = 1'b1;
          bus.div_quotient  = pq;
          bus.div_remainder = pr;
          busy = 1'b0;
        end else begin
          lat--;
        end
      end
      if (bus.div_valid_in) begin
        issue_cnt++;
        ref_div(bus.div_opcode, bus.div_dividend, bus.div_divisor, pq, pr);
        busy = 1'b1;
        lat  = DIV_LAT - 1;
      end
      if (stray_req) begin
        bus.div_valid_out = 1'b1;
        bus.div_quotient  = 32'h5555_5555;
        bus.div_remainder = 32'hAAAA_AAAA;
        stray_req = 1'b0;
      end
    end
  end

  // Response monitor: every accepted response is popped and checked in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {28'd0, bus.rsp_tag}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("rsp_quotient", bus.rsp_quotient, e.q);
          chk("rsp_remainder", bus.rsp_remainder, e.r);
          chk("rsp_tag", {28'd0, bus.rsp_tag}, {28'd0, e.tag});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [31:0] eq, input logic [31:0] er);
    bit accepted = 1'b0;
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_opcode   = op;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_tag      = tag;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clock);
      if (bus.req_ready) accepted = 1'b1;
      step();
    end
    if (accepted) begin
      e.q = eq;
      e.r = er;
      e.tag = tag;
      sb.push_back(e);
    end else begin
      chk("send_accept", 32'd0, 32'd1);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 300) begin
      step();
      n++;
    end
    chk(name, {31'd0, sb.size() == 0}, 32'd1);
  endtask

  initial begin
    int n0;
    int wait_n;
    logic [31:0] fa [4] = '{32'd20, 32'd33, 32'd45, 32'd61};
    logic [31:0] fb [4] = '{32'd3, 32'd4, 32'd6, 32'd7};
    logic [31:0] fq [4] = '{32'd6, 32'd8, 32'd7, 32'd8};
    logic [31:0] fr [4] = '{32'd2, 32'd1, 32'd3, 32'd5};

    bus.req_valid    = 1'b0;
    bus.req_opcode   = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.req_tag      = '0;
    bus.rsp_ready    = 1'b1;

    // Reset values
    #2;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_div_valid_in", {31'd0, bus.div_valid_in}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_quotient", bus.rsp_quotient, 32'd0);
    chk("rst_div_dividend", bus.div_dividend, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Unsigned basic with issue latency
    n0 = issue_cnt;
    send(DIV_OP_UNSIGNED, 32'd100, 32'd7, 4'd3, 32'd14, 32'd2);
    chk("lat_e0_div_valid_in", {31'd0, bus.div_valid_in}, 32'd0);
    step();
    chk("lat_e1_div_valid_in", {31'd0, bus.div_valid_in}, 32'd1);
    chk("lat_e1_div_dividend", bus.div_dividend, 32'd100);
    chk("lat_e1_div_divisor", bus.div_divisor, 32'd7);
    step();
    chk("lat_e2_div_valid_in", {31'd0, bus.div_valid_in}, 32'd0);
    wait_drain("unsigned_drain");
    chk("unsigned_issue_count", issue_cnt - n0, 32'd1);

    // FIFO fill and ordering behind a held response
    bus.rsp_ready = 1'b0;
    n0 = issue_cnt;
    send(DIV_OP_UNSIGNED, 32'd50, 32'd5, 4'd9, 32'd10, 32'd0);
    for (int i = 0; i < 4; i++)
      send(DIV_OP_UNSIGNED, fa[i], fb[i], 4'(i), fq[i], fr[i]);
    chk("fill_req_ready", {31'd0, bus.req_ready}, 32'd0);
    step();
    step();
    chk("fill_req_ready_held", {31'd0, bus.req_ready}, 32'd0);
    bus.rsp_ready = 1'b1;
    wait_drain("fill_drain");
    chk("fill_issue_count", issue_cnt - n0, 32'd5);
    chk("fill_req_ready_after", {31'd0, bus.req_ready}, 32'd1);

    // Response backpressure
    bus.rsp_ready = 1'b0;
    send(DIV_OP_UNSIGNED, 32'd1000, 32'd10, 4'd5, 32'd100, 32'd0);
    send(DIV_OP_UNSIGNED, 32'd77, 32'd5, 4'd6, 32'd15, 32'd2);
    wait_n = 0;
    while (!bus.rsp_valid && wait_n < 50) begin
      step();
      wait_n++;
    end
    chk("bp_rsp_valid_rise", {31'd0, bus.rsp_valid}, 32'd1);
    n0 = issue_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_hold_quotient", bus.rsp_quotient, 32'd100);
      chk("bp_hold_tag", {28'd0, bus.rsp_tag}, 32'd5);
      chk("bp_hold_no_issue", {31'd0, bus.div_valid_in}, 32'd0);
    end
    chk("bp_issue_count", issue_cnt - n0, 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release_idle", {31'd0, bus.div_valid_in}, 32'd0);
    chk("bp_release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("bp_release_issue", {31'd0, bus.div_valid_in}, 32'd1);
    chk("bp_release_dividend", bus.div_dividend, 32'd77);
    wait_drain("bp_drain");

    // Signed
    send(DIV_OP_SIGNED, 32'hFFFF_FFF9, 32'd2, 4'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    wait_drain("signed_drain");

    // Divide by zero
    n0 = issue_cnt;
    send(DIV_OP_UNSIGNED, 32'h1234, 32'd0, 4'd8, 32'hFFFF_FFFF, 32'h1234);
    wait_drain("divzero_drain");
`ifdef DIV_DISPATCH_ZERO_BYPASS_EN
    chk("divzero_issue_count", issue_cnt - n0, 32'd0);
`else
    chk("divzero_issue_count", issue_cnt - n0, 32'd1);
`endif

    // Reset while busy with two entries queued
    send(DIV_OP_SIGNED, 32'hDEAD, 32'd3, 4'd1, 32'd0, 32'd0);
    send(DIV_OP_UNSIGNED, 32'd9, 32'd2, 4'd2, 32'd0, 32'd0);
    send(DIV_OP_UNSIGNED, 32'd8, 32'd2, 4'd4, 32'd0, 32'd0);
    chk("mid_req_busy_dividend", bus.div_dividend, 32'hDEAD);
    reset = 1'b0;
    sb.delete();
    n0 = issue_cnt;
    #1;
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_div_valid_in", {31'd0, bus.div_valid_in}, 32'd0);
    chk("mid_rst_div_opcode", {31'd0, bus.div_opcode}, 32'd0);
    chk("mid_rst_div_dividend", bus.div_dividend, 32'd0);
    chk("mid_rst_div_divisor", bus.div_divisor, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_rsp_remainder", bus.rsp_remainder, 32'd0);
    chk("mid_rst_rsp_tag", {28'd0, bus.rsp_tag}, 32'd0);
    step();
    step();
    reset = 1'b1;
    stray_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stray_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("stray_div_valid_in", {31'd0, bus.div_valid_in}, 32'd0);
    end
    chk("stray_issue_count", issue_cnt - n0, 32'd0);
    chk("stray_req_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_int_dispatch.md
# div_int_dispatch

Request buffer and issue stage sitting directly upstream of the multi-cycle integer divider `div_int`. It accepts divide requests over a ready/valid handshake, queues them in a small in-order FIFO, and issues exactly one operation at a time to the divider. It captures each divider result together with the request tag and returns it over a ready/valid response port with full backpressure.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `TAG_W`, 4: request tag width.
- `XLEN`, 32: operand width.

- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on this edge when `req_valid` is also high.
- `req_opcode` in 1: 0 = unsigned, 1 = signed.
- `req_dividend` in XLEN: request dividend.
- `req_divisor` in XLEN: request divisor.
- `req_tag` in TAG_W: request tag, returned with the result.
- `div_valid_in` out 1: single-cycle issue pulse to the divider.
- `div_opcode` out 1: operand register driven to the divider.
- `div_dividend` out XLEN: operand register driven to the divider.
- `div_divisor` out XLEN: operand register driven to the divider.
- `div_valid_out` in 1: divider result strobe.
- `div_quotient` in XLEN: divider quotient.
- `div_remainder` in XLEN: divider remainder.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_quotient` out XLEN: registered response quotient.
- `rsp_remainder` out XLEN: registered response remainder.
- `rsp_tag` out TAG_W: registered response tag.

## Operation
- **FIFO**
  - `req_ready = !full`, combinational from the occupancy count only.
  - Push on `req_valid && req_ready`.
  - Push and pop in the same cycle are both honoured when not full.
  - No pop when empty.
  - Entries are issued strictly in arrival order.
- **FSM states:** S_IDLE, S_BUSY, S_HOLD.
  - **S_IDLE**, FIFO non-empty: pop the head. Load `div_opcode`, `div_dividend` and `div_divisor`. Latch the tag into the in-flight register. Pulse `div_valid_in` high for one cycle. Go to S_BUSY.
  - **S_IDLE**, FIFO empty: stay in S_IDLE.
  - **S_BUSY:** wait for `div_valid_out`. On it, register quotient, remainder and in-flight tag into the `rsp_*` registers, set `rsp_valid`, and go to S_HOLD.
  - **S_HOLD:** when `rsp_valid && rsp_ready`, clear `rsp_valid` and go to S_IDLE.
- Operand registers stay stable from issue until the next issue.
- `div_valid_out` is ignored in S_IDLE and S_HOLD. This covers stray strobes after reset.
- At most one operation is outstanding in the divider. A new issue never occurs while a response is held.
- **Reset values** (`reset` low, asynchronous):
  - FIFO pointers and count cleared, so `req_ready`=1.
  - FSM state S_IDLE.
  - `div_valid_in`=0, `div_opcode`=0, `div_dividend`=0, `div_divisor`=0.
  - `rsp_valid`=0, `rsp_quotient`=0, `rsp_remainder`=0, `rsp_tag`=0.
- **Reset mid-operation:** any in-flight or queued request is discarded with no response. The divider shares the same reset.

## Timing
- A request accepted at edge E0 enters the FIFO.
- If the FSM is in S_IDLE with the FIFO empty, the head is popped at E1, and `div_valid_in` is high during the cycle after E1.
- `rsp_valid` rises on the edge that samples `div_valid_out` high.
- Minimum gap between successive issues: divider latency + 2 cycles, i.e. the S_HOLD handshake cycle plus the S_IDLE issue cycle.
- `rsp_*` outputs are stable while `rsp_valid && !rsp_ready`.

## Configuration
- `DIV_DISPATCH_ZERO_BYPASS_EN`
  - **Defined:** in S_IDLE, a head entry with divisor == 0 is popped without issuing to the divider. The response is loaded directly with quotient = all ones, remainder = dividend, and the entry's tag, then the FSM goes to S_HOLD. `rsp_valid` is high one cycle after the pop edge, and `div_valid_in` stays 0.
  - **Not defined:** zero divisors are issued to the divider like any other request, and its result is returned unchanged.

## Structure
- **Shared package `div_pkg`:**
  - `DIV_OP_UNSIGNED`=0, `DIV_OP_SIGNED`=1.
  - FSM state enum.
  - Default `XLEN`.
  - Request entry struct {opcode, dividend, divisor, tag}.
- **Sub-module `div_req_fifo`:** synchronous FIFO with `DEPTH` entries of width 1+2·XLEN+TAG_W. It provides full and empty flags and uses the same asynchronous active-low reset.

## Test plan
- **Unsigned basic:** unsigned 100/7, tag 3 → exactly one `div_valid_in` pulse; response quotient=14, remainder=2, `rsp_tag`=3.
- **FIFO fill and ordering:** 4 back-to-back requests (tags 0..3) while the divider is busy → `req_ready`=0 once 4 entries are held; responses return in order with tags 0,1,2,3.
- **Response backpressure:** hold `rsp_ready` low for 10 cycles → `rsp_*` held stable and no further `div_valid_in` pulses; releasing it gives the next issue two cycles later.
- **Signed:** signed 0xFFFFFFF9 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Divide by zero:** 0x1234 / 0
  - With `DIV_DISPATCH_ZERO_BYPASS_EN`: no `div_valid_in`; response quotient 0xFFFFFFFF, remainder 0x1234.
  - Without it: one `div_valid_in` pulse and the divider's result is passed through.
- **Reset mid-operation:** drop `reset` while in S_BUSY with 2 entries queued → all outputs take their reset values immediately; a later `div_valid_out` produces no `rsp_valid`.
